keypad_scan_decoder: RTL and testbench

//   Input-side counterpart of the multiplexed 7-seg display driver: scans a 4x4 matrix

---
 rtl/keypad_scan_decoder_if.sv | 25 ++
 rtl/keypad_scan_decoder.sv | 180 ++++++++++++++++++
 tb/tb_keypad_scan_decoder.sv | 170 +++++++++++++++++
 3 files changed

// File: rtl/keypad_scan_decoder_if.sv
// Keypad pin and decoded-key bundle between the scan decoder and its neighbours.
// The decoder owns column drive and key outputs; the board/consumer side owns the rows.
interface keypad_scan_decoder_if;
  logic [3:0] row;
  logic [3:0] col;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;

  modport master (
    input  row,
    output col,
    output key_code,
    output key_valid,
    output key_held
  );

  modport slave (
    output row,
    input  col,
    input  key_code,
    input  key_valid,
    input  key_held
  );
endinterface

// File: rtl/keypad_scan_decoder.sv
// 4x4 matrix keypad scanner: drives one column at a time, samples rows once per dwell,
// and debounces whole-scan results into a single accepted hex key code.
module keypad_scan_decoder #(
  parameter int SCAN_BITS = 16,
  parameter int DB_SCANS  = 4
) (
  input  logic                  clk,
  input  logic                  reset_n,
  keypad_scan_decoder_if.master kp
);

  localparam int CNT_W = SCAN_BITS + 2;
  localparam int DB_W  = $clog2(DB_SCANS + 1);

  typedef enum logic [1:0] {
    IDLE,
    PRESS,
    HELD
  } state_t;

  logic [CNT_W-1:0] scan_cnt;
  logic [CNT_W-1:0] scan_cnt_next;
  logic [1:0]       col_idx;
  logic [1:0]       col_idx_next;
  logic [3:0]       col_q;
  logic [3:0]       sync1;
  logic [3:0]       sync2;
  logic             dwell_end;
  logic             scan_end;

  assign scan_cnt_next = scan_cnt + CNT_W'(1);
  assign col_idx       = scan_cnt[CNT_W-1 -: 2];
  assign col_idx_next  = scan_cnt_next[CNT_W-1 -: 2];
  assign dwell_end     = &scan_cnt[SCAN_BITS-1:0];
  assign scan_end      = &scan_cnt;

  // Column drive follows the counter value being loaded, so col stays aligned with col_idx.
  always_ff @(posedge clk) begin
    if (!reset_n) begin
      scan_cnt <= '0;
      col_q    <= 4'b1110;
      sync1    <= 4'b1111;
      sync2    <= 4'b1111;
    end else begin
      scan_cnt <= scan_cnt_next;
      col_q    <= ~(4'b0001 << col_idx_next);
      sync1    <= kp.row;
      sync2    <= sync1;
    end
  end

  assign kp.col = col_q;

  logic [3:0] hit;
  logic [2:0] hit_sum;
  logic [1:0] sample_hits;
  logic [1:0] row_idx;
  logic [1:0] acc_hits;
  logic [3:0] acc_code;
  logic [2:0] scan_sum;
  logic [1:0] scan_hits;
  logic [3:0] scan_code;

  // Running scan result including the sample taken this cycle; counts saturate at 2.
  always_comb begin
    hit         = ~sync2;
    hit_sum     = {2'b00, hit[0]} + {2'b00, hit[1]} + {2'b00, hit[2]} + {2'b00, hit[3]};
    sample_hits = 2'd0;
    if (dwell_end) begin
      sample_hits = (hit_sum >= 3'd2) ? 2'd2 : hit_sum[1:0];
    end
    row_idx = 2'd0;
    if (hit[0])      row_idx = 2'd0;
    else if (hit[1]) row_idx = 2'd1;
    else if (hit[2]) row_idx = 2'd2;
    else if (hit[3]) row_idx = 2'd3;
    scan_sum  = {1'b0, acc_hits} + {1'b0, sample_hits};
    scan_hits = (scan_sum >= 3'd2) ? 2'd2 : scan_sum[1:0];
    scan_code = (acc_hits == 2'd0) ? {col_idx, row_idx} : acc_code;
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      acc_hits <= 2'd0;
      acc_code <= 4'd0;
    end else if (scan_end) begin
      acc_hits <= 2'd0;
      acc_code <= 4'd0;
    end else if (dwell_end) begin
      acc_hits <= scan_hits;
      acc_code <= scan_code;
    end
  end

  state_t          state;
  state_t          state_next;
  logic [3:0]      cand;
  logic [3:0]      cand_next;
  logic [DB_W-1:0] db_cnt;
  logic [DB_W-1:0] db_cnt_next;
  logic [DB_W-1:0] db_cnt_inc;
  logic            db_reached;
  logic [3:0]      key_code_q;
  logic [3:0]      key_code_next;
  logic            key_valid_q;
  logic            accept;

  assign db_cnt_inc = db_cnt + DB_W'(1);
  assign db_reached = (db_cnt_inc == DB_W'(DB_SCANS));

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      state       <= IDLE;
      cand        <= 4'd0;
      db_cnt      <= '0;
      key_code_q  <= 4'd0;
      key_valid_q <= 1'b0;
    end else begin
      state       <= state_next;
      cand        <= cand_next;
      db_cnt      <= db_cnt_next;
      key_code_q  <= key_code_next;
      key_valid_q <= accept;
    end
  end

  // Debounce decisions happen only on the scan-end cycle; everything else holds.
  always_comb begin
    state_next    = state;
    cand_next     = cand;
    db_cnt_next   = db_cnt;
    key_code_next = key_code_q;
    accept        = 1'b0;
    if (scan_end) begin
      case (state)
        IDLE: begin
          if (scan_hits == 2'd1) begin
            cand_next   = scan_code;
            db_cnt_next = DB_W'(1);
            state_next  = PRESS;
          end
        end
        PRESS: begin
          if (scan_hits == 2'd1 && scan_code == cand) begin
            db_cnt_next = db_cnt_inc;
            if (db_reached) begin
              key_code_next = cand;
              accept        = 1'b1;
              db_cnt_next   = '0;
              state_next    = HELD;
            end
          end else begin
            db_cnt_next = '0;
            state_next  = IDLE;
          end
        end
        HELD: begin
          if (scan_hits == 2'd0) begin
            db_cnt_next = db_cnt_inc;
            if (db_reached) begin
              db_cnt_next = '0;
              state_next  = IDLE;
            end
          end else begin
            db_cnt_next = '0;
          end
        end
        default: begin
          db_cnt_next = '0;
          state_next  = IDLE;
        end
      endcase
    end
  end

  assign kp.key_code  = key_code_q;
  assign kp.key_valid = key_valid_q;
  assign kp.key_held  = (state == HELD);

endmodule

// File: tb/tb_keypad_scan_decoder.sv
// Self-checking bench: a keypad matrix model plus a scan-level reference of the debouncer,
// driven by directed cases followed by randomized press patterns and resets.
module tb_keypad_scan_decoder;

  localparam int SCAN_BITS = 2;
  localparam int DB_SCANS  = 3;
  localparam int SCAN_LEN  = 16;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic [15:0] pressed = 16'h0000;
  logic [3:0]  row_drive;

  always #5 clk = ~clk;

  keypad_scan_decoder_if bus();

  keypad_scan_decoder #(
    .SCAN_BITS(SCAN_BITS),
    .DB_SCANS (DB_SCANS)
  ) dut (
    .clk    (clk),
    .reset_n(reset_n),
    .kp     (bus)
  );

  // Key (c,r) pulls row r low while column c is driven low.
  always_comb begin
    row_drive = 4'hF;
    for (int c = 0; c < 4; c++)
      for (int r = 0; r < 4; r++)
        if (pressed[c*4+r] && !bus.col[c]) row_drive[r] = 1'b0;
  end
  assign bus.row = row_drive;

  int compared   = 0;
  int mismatched = 0;

  task automatic checkOutput(input string tag, input logic [7:0] actual, input logic [7:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", tag, actual, expected, $time);
    end
  endtask

  // Scan-level reference: one step per full scan, using the set of keys held during it.
  bit         m_held;
  bit         m_pressing;
  bit         m_pulse;
  logic [3:0] m_cand;
  logic [3:0] m_code;
  int         m_cnt;

  task automatic model_reset();
    m_held = 0; m_pressing = 0; m_pulse = 0;
    m_cand = 4'd0; m_code = 4'd0; m_cnt = 0;
  endtask

  task automatic model_scan(input logic [15:0] mask);
    int         n;
    logic [3:0] low;
    n   = $countones(mask);
    low = 4'd0;
    for (int k = 15; k >= 0; k--) if (mask[k]) low = 4'(k);
    m_pulse = 0;
    if (m_held) begin
      if (n == 0) begin
        m_cnt++;
        if (m_cnt == DB_SCANS) begin m_cnt = 0; m_held = 0; end
      end else m_cnt = 0;
    end else if (m_pressing) begin
      if (n == 1 && low == m_cand) begin
        m_cnt++;
        if (m_cnt == DB_SCANS) begin
          m_code = m_cand; m_pulse = 1; m_cnt = 0; m_pressing = 0; m_held = 1;
        end
      end else begin
        m_cnt = 0; m_pressing = 0;
      end
    end else if (n == 1) begin
      m_cand = low; m_cnt = 1; m_pressing = 1;
    end
  endtask

  // Runs one full scan starting in the counter==0 cycle with the given key set held.
  task automatic applyStimulus(input logic [15:0] mask);
    logic [3:0] exp_col;
    pressed = mask;
    for (int i = 0; i < SCAN_LEN; i++) begin
      exp_col = ~(4'b0001 << (i / 4));
      checkOutput("col", {4'h0, bus.col}, {4'h0, exp_col});
      checkOutput("key_valid", {7'h0, bus.key_valid}, {7'h0, (i == 0) ? m_pulse : 1'b0});
      if (i == 0) begin
        checkOutput("key_held", {7'h0, bus.key_held}, {7'h0, m_held});
        checkOutput("key_code", {4'h0, bus.key_code}, {4'h0, m_code});
      end
      @(negedge clk);
    end
    model_scan(mask);
  endtask

  task automatic do_reset(input int cycles);
    reset_n = 1'b0;
    repeat (cycles) @(negedge clk);
    checkOutput("rst_col", {4'h0, bus.col}, 8'h0E);
    checkOutput("rst_key_valid", {7'h0, bus.key_valid}, 8'h00);
    checkOutput("rst_key_held", {7'h0, bus.key_held}, 8'h00);
    checkOutput("rst_key_code", {4'h0, bus.key_code}, 8'h00);
    reset_n = 1'b1;
    model_reset();
  endtask

  function automatic logic [15:0] key(input int c, input int r);
    logic [15:0] m;
    m = 16'h0001 << (c * 4 + r);
    return m;
  endfunction

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation did not complete, got timeout expected finish");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    logic [15:0] mask;
    int          kind;
    int          hold;
    model_reset();
    @(negedge clk);
    do_reset(3);

    applyStimulus(16'h0000);
    repeat (4) applyStimulus(key(2, 1));
    checkOutput("case2_code", {4'h0, bus.key_code}, 8'h09);
    repeat (4) applyStimulus(16'h0000);

    repeat (2) applyStimulus(key(1, 3));
    applyStimulus(16'h0000);
    repeat (2) applyStimulus(key(1, 3));
    repeat (3) applyStimulus(16'h0000);

    repeat (5) applyStimulus(key(0, 0) | key(3, 3));
    repeat (4) applyStimulus(key(3, 3));
    repeat (4) applyStimulus(16'h0000);

    repeat (4) applyStimulus(key(1, 2));
    do_reset(1);
    repeat (4) applyStimulus(key(1, 2));
    checkOutput("case6_code", {4'h0, bus.key_code}, 8'h06);
    repeat (4) applyStimulus(16'h0000);

    for (int it = 0; it < 60; it++) begin
      kind = $urandom_range(0, 9);
      if (kind < 3)      mask = 16'h0000;
      else if (kind < 8) mask = key($urandom_range(0, 3), $urandom_range(0, 3));
      else               mask = key($urandom_range(0, 3), $urandom_range(0, 3))
                              | key($urandom_range(0, 3), $urandom_range(0, 3));
      hold = $urandom_range(1, 5);
      repeat (hold) applyStimulus(mask);
      if ($urandom_range(0, 19) == 0) do_reset($urandom_range(1, 3));
    end
    repeat (4) applyStimulus(16'h0000);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
